bcd_down_timer: RTL
===================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 Parameter AUTO_RELOAD, default 0, 1 = restart from stored load value on reaching zero.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  single-cycle pulse, captures load_val into counter and reload register.
REQ-006 load_val  input  4*DIGITS  packed BCD preset, digit 0 in bits [3:0].
REQ-007 start  input  1  single-cycle pulse, begins or resumes counting.
REQ-008 stop  input  1  single-cycle pulse, pauses counting.
REQ-009 tick  input  1  count enable qualifier; one decrement per cycle with tick=1 while running.
REQ-010 cnt  output  4*DIGITS  registered packed BCD count value.
REQ-011 bout  output  1  registered borrow-out pulse, one cycle, on reaching zero.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding free; all outputs registered.
REQ-015 Control priority SHALL be load > stop > start when asserted in the same cycle.
REQ-016 load in any state SHALL, next cycle: cnt = load_val, reload register = load_val, state = IDLE, bout = 0.
REQ-017 On load, any digit of load_val greater than 9 SHALL be stored as 9.
REQ-018 start in IDLE with cnt != 0 SHALL enter RUN next cycle; start in IDLE with cnt == 0 SHALL be ignored.
REQ-019 start in DONE SHALL copy reload register into cnt and enter RUN next cycle; ignored if reload register == 0.
REQ-020 start in RUN SHALL have no effect.
REQ-021 stop in RUN SHALL enter IDLE next cycle with cnt held; stop in IDLE or DONE SHALL have no effect.
REQ-022 In RUN, with tick=1, cnt SHALL decrement by one in BCD: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
REQ-023 tick=0 in RUN, or any tick outside RUN, SHALL leave cnt unchanged.
REQ-024 When a RUN decrement takes cnt from 1 to 0, bout SHALL be 1 in the cycle cnt first reads 0, and 0 otherwise.
REQ-025 AUTO_RELOAD=0: on that same transition the state SHALL become DONE, cnt holds 0.
REQ-026 AUTO_RELOAD=1: the next tick after cnt reaches 0 SHALL load the reload register into cnt, with no decrement that cycle; state stays RUN.
REQ-027 Latency from tick to updated cnt SHALL be one clock; from load/start/stop to state change, one clock.
REQ-028 A stop coinciding with the 1->0 decrement SHALL take priority: the decrement is suppressed, cnt holds 1, state = IDLE, bout = 0.

Reset
REQ-029 rstn=0 SHALL immediately force state = IDLE, cnt = 0, reload register = 0, bout = 0, busy = 0, done = 0.
REQ-030 Release of rstn SHALL be synchronised to clk externally; after release, the first active edge behaves per REQ-015..028.
REQ-031 Reset asserted mid-RUN SHALL abort counting with no bout pulse.

Verification
REQ-032 load 0x0012, start, tick held 1 -> cnt 0012,0011,0010,0009,...,0001,0000; bout=1 only on 0000; done=1 thereafter.
REQ-033 load 0x1000, start, one tick -> cnt 0999 (multi-digit borrow); stop -> busy=0, cnt holds 0999.
REQ-034 AUTO_RELOAD=1, load 0x0003, start, tick=1 -> 3,2,1,0(bout),3,2,... continuously; busy stays 1.
REQ-035 load 0x00AF -> cnt 0099; start with cnt 0000 after reset -> stays IDLE, busy=0.
REQ-036 load, stop, start in the same cycle during RUN -> load wins, state IDLE, cnt = load_val.
REQ-037 rstn low mid-RUN at cnt 0005 -> cnt 0000, busy 0, done 0, no bout within the same cycle.

Source files
------------

// File: rtl/bcd_down_timer.sv
// Cascaded BCD down-counter with load/start/stop control and borrow-out.
// Optional auto-reload restarts from the stored preset after reaching zero.
module bcd_down_timer #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  bout,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic [4*DIGITS-1:0] rel_q, rel_d;
    logic                bout_q, bout_d;
    logic                busy_q, done_q;

    function automatic logic [4*DIGITS-1:0] bcd_sat(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple the borrow up through the digits; a 0 digit wraps to 9.
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        bout_d  = 1'b0;
        if (load) begin
            cnt_d   = bcd_sat(load_val);
            rel_d   = bcd_sat(load_val);
            state_d = S_IDLE;
        end else if (stop) begin
            if (state_q == S_RUN) state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (cnt_q != '0)) state_d = S_RUN;
                end
                S_DONE: begin
                    if (start && (rel_q != '0)) begin
                        cnt_d   = rel_q;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (cnt_q == '0) begin
                            if (AUTO_RELOAD) cnt_d = rel_q;
                            else state_d = S_DONE;
                        end else begin
                            cnt_d = bcd_dec(cnt_q);
                            if (cnt_d == '0) begin
                                bout_d = 1'b1;
                                if (!AUTO_RELOAD) state_d = S_DONE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rel_q   <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            bout_q  <= bout_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign cnt  = cnt_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
